// File: rtl/sat_subtractor_pipe.sv
// sat_subtractor_pipe: pipelined signed a-b / a+b / b-a / |a-b| with
// saturation or wrap, a travelling valid strobe and a sticky overflow flag.
// Optional build macro SAT_SUB_OVF_COUNT_EN adds the 16-bit ovf_count output.
module sat_subtractor_pipe #(
  parameter int WIDTH    = 16,
  parameter int LATENCY  = 2,
  parameter int SATURATE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] input_one,
  input  logic [WIDTH-1:0] input_two,
  input  logic             clear_sticky,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
`ifdef SAT_SUB_OVF_COUNT_EN
  output logic             ovf_sticky,
  output logic [15:0]      ovf_count
`else
  output logic             ovf_sticky
`endif
);

  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] s1_a, s1_b;
  logic [1:0]       s1_mode;
  logic             s1_vld;

  logic [WIDTH:0]   a_ext, b_ext, diff, full;
  logic             s1_ovf_raw, s1_ovf;
  logic [WIDTH-1:0] s1_res;

  // Stage 1: capture operands and mode only for accepted samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_a    <= '0;
      s1_b    <= '0;
      s1_mode <= '0;
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_a    <= input_one;
        s1_b    <= input_two;
        s1_mode <= mode;
      end
    end
  end

  // Full-precision WIDTH+1 arithmetic, overflow detect and clamp/wrap.
  always_comb begin
    a_ext = {s1_a[WIDTH-1], s1_a};
    b_ext = {s1_b[WIDTH-1], s1_b};
    diff  = a_ext - b_ext;
    case (s1_mode)
      2'b00:   full = diff;
      2'b01:   full = a_ext + b_ext;
      2'b10:   full = b_ext - a_ext;
      default: full = diff[WIDTH] ? (~diff + 1'b1) : diff;
    endcase
    s1_ovf_raw = full[WIDTH] ^ full[WIDTH-1];
    if (s1_ovf_raw && (SATURATE != 0))
      s1_res = full[WIDTH] ? MINV : MAXV;
    else
      s1_res = full[WIDTH-1:0];
    s1_ovf = s1_ovf_raw & s1_vld;
  end

  generate
    if (LATENCY == 1) begin : g_direct
      // Stage-1 operands hold between samples, so the result holds too.
      assign out_valid = s1_vld;
      assign overflow  = s1_ovf;
      assign result    = s1_res;
    end else begin : g_pipe
      localparam int unsigned NREG = LATENCY - 1;
      logic [WIDTH-1:0] p_res [NREG];
      logic             p_ovf [NREG];
      logic             p_vld [NREG];

      // Delay line; result registers only load on valid so the output holds.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int unsigned i = 0; i < NREG; i++) begin
            p_res[i] <= '0;
            p_ovf[i] <= 1'b0;
            p_vld[i] <= 1'b0;
          end
        end else begin
          p_vld[0] <= s1_vld;
          p_ovf[0] <= s1_ovf;
          if (s1_vld) p_res[0] <= s1_res;
          for (int unsigned i = 1; i < NREG; i++) begin
            p_vld[i] <= p_vld[i-1];
            p_ovf[i] <= p_ovf[i-1];
            if (p_vld[i-1]) p_res[i] <= p_res[i-1];
          end
        end
      end

      assign out_valid = p_vld[NREG-1];
      assign overflow  = p_ovf[NREG-1];
      assign result    = p_res[NREG-1];
    end
  endgenerate

  // Sticky overflow flag; a new overflow beats a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      ovf_sticky <= 1'b0;
    else if (out_valid && overflow)
      ovf_sticky <= 1'b1;
    else if (clear_sticky)
      ovf_sticky <= 1'b0;
  end

`ifdef SAT_SUB_OVF_COUNT_EN
  // Saturating overflow event counter; clear with coincident event yields 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      ovf_count <= '0;
    else if (clear_sticky)
      ovf_count <= (out_valid && overflow) ? 16'd1 : '0;
    else if (out_valid && overflow && (ovf_count != '1))
      ovf_count <= ovf_count + 16'd1;
  end
`endif

endmodule

// File: doc/sat_subtractor_pipe.md
Name: sat_subtractor_pipe

Overview:
Parametrised successor to the single-cycle signed subtractor in the PWM decoder datapath. Computes a - b, a + b, b - a or |a - b| on signed WIDTH-bit samples, with saturation and a programmable pipeline depth. A valid strobe travels with each sample. Sits between the PWM edge-timestamp capture and the demodulator filter, where it forms pulse-width and period differences.

Parameters:
WIDTH, 16, sample width in bits (signed two's complement), range 4..32
LATENCY, 2, clock cycles from in_valid to out_valid, range 1..8
SATURATE, 1, 1 = clamp to the signed range, 0 = two's-complement wrap

Ports:
clock  input  1  system clock; all logic on the rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input sample strobe
mode  input  2  00 a-b, 01 a+b, 10 b-a, 11 |a-b|; sampled with in_valid
input_one  input  WIDTH  operand a, signed
input_two  input  WIDTH  operand b, signed
clear_sticky  input  1  synchronous clear of ovf_sticky
out_valid  output  1  result strobe, one cycle per accepted sample
result  output  WIDTH  signed result
overflow  output  1  qualified by out_valid: this result saturated or wrapped
ovf_sticky  output  1  set by any overflow since the last clear or reset

Behaviour:
- Reset is asynchronous and active-high: while reset=1, all state clears immediately. result=0, out_valid=0, overflow=0, ovf_sticky=0, all pipeline valid bits=0.
- Reset asserted mid-operation drops in-flight samples. No out_valid follows until new in_valid samples arrive after reset deasserts.
- Stage 1 latches the operands, mode and valid when in_valid=1. Operands are sign-extended to WIDTH+1 bits.
- Stage 1 then computes the full-precision WIDTH+1 result:
  - a-b, a+b or b-a according to mode.
  - mode 11 gives |a-b| as a non-negative WIDTH+1 value.
- Overflow: the WIDTH+1 result falls outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- SATURATE=1: on overflow, clamp to 2^(WIDTH-1)-1 (positive) or -2^(WIDTH-1) (negative). |a-b| never goes negative and clamps to max.
- SATURATE=0: take the low WIDTH bits and still flag overflow.
- The remaining LATENCY-1 stages are plain registers on result, overflow and valid.
- LATENCY=1 gives a single-register output, the same timing as the legacy subtractor.
- Throughput: one sample per clock. Back-to-back in_valid is fully supported. There is no backpressure.
- When out_valid=0:
  - result holds its last valid value.
  - overflow holds 0.
- Gaps in in_valid propagate as gaps in out_valid with the same spacing.
- ovf_sticky sets in the cycle after out_valid=1 with overflow=1. It stays set until clear_sticky=1.
- If clear_sticky and a new overflow occur in the same cycle, set wins and ovf_sticky stays 1.
- mode and operands are ignored when in_valid=0.

Optional Feature:
Macro SAT_SUB_OVF_COUNT_EN.
- Defined: adds output ovf_count, 16 bits.
  - Increments once per out_valid with overflow=1.
  - Saturates at 16'hFFFF; does not wrap.
  - Clears to 0 on reset or clear_sticky.
  - If clear_sticky and an overflow coincide, ovf_count becomes 1.
- Not defined: the port and its counter logic do not exist. All other behaviour is unchanged.

Test Plan:
- WIDTH=16, LATENCY=2, mode 00, a=1000, b=250, in_valid for one cycle -> out_valid exactly 2 cycles later, result=750, overflow=0.
- mode 00, a=-32768, b=1, with SATURATE=1 -> result=-32768, overflow=1, ovf_sticky=1 on the next cycle. With SATURATE=0 -> result=32767, overflow=1.
- mode 11, a=-32768, b=32767 -> result=32767 (saturated), overflow=1. mode 11, a=-5, b=7 -> result=12. mode 10, a=3, b=10 -> result=7.
- Four back-to-back samples a=1,2,3,4 with b=0, then a one-cycle gap, then a=5 -> out_valid pattern 1,1,1,1,0,1 and results 1,2,3,4,5 in order.
- Reset asserted while 2 samples are in flight -> out_valid, result and ovf_sticky go to 0 immediately, asynchronously. No out_valid appears after release until new input arrives.
- SAT_SUB_OVF_COUNT_EN defined: 3 overflowing samples -> ovf_count=3. Then clear_sticky in the same cycle as a 4th overflow -> ovf_sticky=1 and ovf_count=1.
